// File: rtl/dp_postproc.sv
// Dot-product post-processing: tile accumulation, bias, optional ReLU,
// rounding requantization with saturation, registered valid/ready output.
module dp_postproc #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned MAX_TILES  = 16,
  parameter int unsigned TILE_W     = $clog2(MAX_TILES + 1),
  parameter int unsigned SHIFT_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [TILE_W-1:0]     cfg_tiles,
  input  logic [SHIFT_W-1:0]    cfg_shift,
  input  logic                  cfg_relu,
  input  logic [ACC_WIDTH-1:0]  bias,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ACC_WIDTH-1:0]  in_dp,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sat,
  output logic                  busy
);

  localparam logic [TILE_W-1:0] MAX_T = TILE_W'(MAX_TILES);
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    (ACC_WIDTH+1)'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = -SAT_MAX - (ACC_WIDTH+1)'(1);

  logic [ACC_WIDTH-1:0]  acc;
  logic [TILE_W-1:0]     cnt;
  logic [TILE_W-1:0]     tiles_q;
  logic [SHIFT_W-1:0]    shift_q;
  logic                  relu_q;

  logic                  first;
  logic                  accept;
  logic                  last;
  logic [TILE_W-1:0]     cfg_tiles_clamped;
  logic [TILE_W-1:0]     tiles_eff;
  logic [SHIFT_W-1:0]    shift_eff;
  logic                  relu_eff;
  logic [ACC_WIDTH-1:0]  sum;
  logic [ACC_WIDTH-1:0]  relu_sum;
  logic signed [ACC_WIDTH:0] sum_ext;
  logic signed [ACC_WIDTH:0] rnd_add;
  logic signed [ACC_WIDTH:0] rsum;
  logic signed [ACC_WIDTH:0] rounded;
  logic [DATA_WIDTH-1:0] q_data;
  logic                  q_sat;

  // A pending output blocks new partials unless it is drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign first    = (cnt == '0);

  // Effective group config, accumulate step and requantization of the sum.
  always_comb begin
    cfg_tiles_clamped = cfg_tiles;
    if (cfg_tiles == '0) begin
      cfg_tiles_clamped = TILE_W'(1);
    end else if (cfg_tiles > MAX_T) begin
      cfg_tiles_clamped = MAX_T;
    end
    tiles_eff = first ? cfg_tiles_clamped : tiles_q;
    shift_eff = first ? cfg_shift : shift_q;
    relu_eff  = first ? cfg_relu : relu_q;
    last      = (cnt == tiles_eff - TILE_W'(1));

    sum      = (first ? bias : acc) + in_dp;
    relu_sum = (relu_eff && sum[ACC_WIDTH-1]) ? '0 : sum;
    sum_ext  = $signed({relu_sum[ACC_WIDTH-1], relu_sum});
    rnd_add  = '0;
    if (shift_eff != '0) begin
      rnd_add = (ACC_WIDTH+1)'(1) << (shift_eff - SHIFT_W'(1));
    end
    rsum    = sum_ext + rnd_add;
    rounded = rsum >>> shift_eff;

    q_data = rounded[DATA_WIDTH-1:0];
    q_sat  = 1'b0;
    if (rounded > SAT_MAX) begin
      q_data = SAT_MAX[DATA_WIDTH-1:0];
      q_sat  = 1'b1;
    end else if (rounded < SAT_MIN) begin
      q_data = SAT_MIN[DATA_WIDTH-1:0];
      q_sat  = 1'b1;
    end
  end

  // Latch the group configuration on the first accepted partial.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tiles_q <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else if (accept && first) begin
      tiles_q <= cfg_tiles_clamped;
      shift_q <= cfg_shift;
      relu_q  <= cfg_relu;
    end
  end

  // Accumulator and partial counter; busy mirrors cnt != 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (accept) begin
      if (last) begin
        acc  <= '0;
        cnt  <= '0;
        busy <= 1'b0;
      end else begin
        acc  <= sum;
        cnt  <= cnt + TILE_W'(1);
        busy <= 1'b1;
      end
    end
  end

  // Output register: load on final accept, otherwise drain on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (accept && last) begin
      out_valid <= 1'b1;
      out_data  <= q_data;
      out_sat   <= q_sat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/dp_postproc.md
Name: dp_postproc

Overview:
- Downstream stage of the combinational dot-product unit in the NPU datapath.
- Consumes signed ACC_WIDTH partial dot products over a valid/ready handshake.
- Accumulates a configurable number of partials (tiles) into one neuron output, adds bias, optionally applies ReLU, then requantizes (rounding arithmetic right shift plus saturation) to a DATA_WIDTH activation.
- The output goes to a registered valid/ready interface feeding the activation buffer.

Parameters:
- DATA_WIDTH, default `DATA_WIDTH (width.svh): output activation width, signed.
- ACC_WIDTH, default `ACC_WIDTH (width.svh): partial, bias and accumulator width, signed.
- MAX_TILES, default 16: maximum number of partials per output.
- TILE_W, default $clog2(MAX_TILES+1): width of cfg_tiles.
- SHIFT_W, default 5: width of cfg_shift.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cfg_tiles  input  TILE_W  partials per output; 0 treated as 1; values above MAX_TILES clamp to MAX_TILES.
- cfg_shift  input  SHIFT_W  requantization right shift, 0..ACC_WIDTH-1.
- cfg_relu  input  1  1 = clamp negative sums to 0 before shifting.
- bias  input  ACC_WIDTH  signed bias for the current output.
- in_valid  input  1  in_dp valid.
- in_ready  output  1  block accepts in_dp this cycle.
- in_dp  input  ACC_WIDTH  signed partial dot product.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  DATA_WIDTH  signed requantized activation.
- out_sat  output  1  saturation occurred for out_data.
- busy  output  1  a group is partially accumulated (cnt != 0).

Behaviour:
Reset (async, rst_n low):
- acc, cnt and the cfg shadow registers clear to 0.
- out_valid, out_data, out_sat and busy clear to 0.
- Any partially accumulated group is discarded.

Handshake and accept rules:
- Accept occurs when in_valid && in_ready.
- in_ready = !out_valid || out_ready, which is combinational from out_ready.
- Accepting a non-final partial does not touch the output register.
- in_ready is still gated by a pending output. This keeps the logic simple, and is a decided choice.

Per-group configuration:
- On the accept with cnt==0, the block latches tiles_q, shift_q and relu_q from cfg_tiles, cfg_shift and cfg_relu.
- Config changes mid-group are ignored until the next group starts.

Accumulate step (every accept):
- base = (cnt==0) ? bias : acc.
- sum = base + in_dp, computed in ACC_WIDTH bits with two's-complement wrap. No accumulator saturation.
- The effective tile count is cfg_tiles at cnt==0 and tiles_q afterwards.
- Non-final accept: acc <= sum, cnt <= cnt+1.
- Final accept (cnt == effective tiles - 1): cnt <= 0, acc <= 0, and the result is loaded into the output register.

Requantize (combinational on sum at the final accept):
- r = relu ? max(sum,0) : sum.
- Rounding: rounded = (r + (shift>0 ? 1<<(shift-1) : 0)) >>> shift, evaluated in ACC_WIDTH+1 bits so the rounding add cannot overflow. Result is round-half-up toward +inf.
- Saturation: out_data = clamp(rounded, -2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1).
- out_sat = 1 iff clamping changed the value.

Output register and latency:
- out_valid rises on the cycle after the final accept, so latency is 1 cycle.
- out_data and out_sat are held stable while out_valid && !out_ready.
- On out_valid && out_ready with no final accept in the same cycle, out_valid falls.
- When out_valid && out_ready and a final accept happen in the same cycle, the new result is loaded and out_valid stays 1. This sustains full throughput of 1 output per cycle when tiles=1.
- busy = (cnt != 0).

Test Plan:
Bench settings: DATA_WIDTH=8, ACC_WIDTH=32, out_ready=1 unless stated.
1. Single tile, passthrough: cfg_tiles=1, bias=0, shift=0, relu=0, in_dp=100 -> out_valid one cycle after accept, out_data=100, out_sat=0.
2. Multi-tile with bias and shift: cfg_tiles=3, bias=10, partials 50, -20, 40, shift=2 -> sum 80, (80+2)>>>2=20. busy high after partials 1 and 2, then low; out_data=20.
3. Saturation and ReLU:
   - in_dp=1000, shift=0 -> out_data=127, out_sat=1.
   - in_dp=-1000 -> out_data=-128, out_sat=1.
   - in_dp=-1000 with relu=1 -> out_data=0, out_sat=0.
4. Rounding, shift=2: in_dp=6 -> 2; in_dp=5 -> 1; in_dp=-6 -> -1; in_dp=-7 -> -2.
5. Backpressure and back-to-back, tiles=1:
   - Hold out_ready=0 and present in_dp=7, then 9 -> in_ready=0 while out_data=7 is held stable across 3 stall cycles.
   - Raise out_ready -> 9 is loaded in the same cycle 7 is consumed, and out_valid never drops.
   - Continuous stream of 1..8 with out_ready=1 -> 8 outputs on 8 consecutive cycles.
6. Reset mid-group: cfg_tiles=3, accept 2 partials, pulse rst_n low asynchronously (mid-cycle) -> out_valid=0, out_data=0 and busy=0 immediately. The next group (bias=0, partials 1, 2, 3, shift=0) yields 6, not contaminated by the discarded partials.
